dvi_video_timing_gen: RTL and testbench



---
 rtl/dvi_video_pkg.sv | 50 +++++
 rtl/dvi_pattern_gen.sv | 25 ++
 rtl/dvi_video_timing_gen.sv | 150 +++++++++++++++
 tb/tb_dvi_video_timing_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dvi_video_pkg.sv
// Shared definitions for the DVI video timing generator: standard timing sets,
// test-pattern encodings and the colour-bar palette.
package dvi_video_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_WHITE = 2'd3
  } pattern_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  localparam timing_t TIMING_720P  = '{1280, 110, 40, 220, 720, 5, 5, 20};
  localparam timing_t TIMING_1080P = '{1920, 88, 44, 148, 1080, 4, 5, 36};
  localparam timing_t TIMING_480P  = '{640, 16, 96, 48, 480, 10, 2, 33};

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Bars run left to right in descending luminance.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvi_pattern_gen.sv
// Combinational test-pattern lookup: maps the current position, bar index and
// frame-latched pattern selection to a 24-bit RGB pixel.
module dvi_pattern_gen
  import dvi_video_pkg::*;
(
  input  logic [11:0] x,
  input  logic [10:0] y,
  input  logic [2:0]  bar_idx,
  input  pattern_e    pattern,
  output logic [23:0] pixel
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives pixel and no latch is inferred.
    pixel = RGB_BLACK;
    case (pattern)
      PAT_BARS:  pixel = bar_colour(bar_idx);
      PAT_RAMP:  pixel = {3{x[7:0]}};
      PAT_CHECK: pixel = (x[5] ^ y[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_WHITE: pixel = RGB_WHITE;
      default:   pixel = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/dvi_video_timing_gen.sv
// Raster timing and test-pattern source for DVI bring-up; every output is
// registered one cycle after the h/v counter state it decodes.
module dvi_video_timing_gen
  import dvi_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = TIMING_720P.h_active,
  parameter int unsigned H_FP     = TIMING_720P.h_fp,
  parameter int unsigned H_SYNC   = TIMING_720P.h_sync,
  parameter int unsigned H_BP     = TIMING_720P.h_bp,
  parameter int unsigned V_ACTIVE = TIMING_720P.v_active,
  parameter int unsigned V_FP     = TIMING_720P.v_fp,
  parameter int unsigned V_SYNC   = TIMING_720P.v_sync,
  parameter int unsigned V_BP     = TIMING_720P.v_bp,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        den,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] pixel_data,
  output logic [11:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          HW      = $clog2(H_TOTAL);
  localparam int          VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      H_ACTIVE > 4095 || V_ACTIVE > 2047) begin : g_bad_params
    $error("dvi_video_timing_gen: illegal timing parameters");
  end

  logic [HW-1:0] h_cnt, h_nxt, bar_cnt, bar_cnt_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [2:0]    bar_idx, bar_idx_nxt;
  pattern_e      pat_q, pat_nxt, cur_pat;
  logic          sof, h_act, v_act;
  logic [23:0]   pix;
  logic          den_nxt, hsync_nxt, vsync_nxt, fs_nxt;
  logic [23:0]   pix_nxt;
  logic [11:0]   px_nxt;
  logic [10:0]   py_nxt;

  assign sof     = (h_cnt == '0) && (v_cnt == '0);
  assign h_act   = h_cnt < H_ACT_C;
  assign v_act   = v_cnt < V_ACT_C;
  // The pixel at (0,0) already uses the newly sampled selection.
  assign cur_pat = sof ? pattern_e'(pattern_sel) : pat_q;

  dvi_pattern_gen u_pattern (
    .x       (12'(h_cnt)),
    .y       (11'(v_cnt)),
    .bar_idx (bar_idx),
    .pattern (cur_pat),
    .pixel   (pix)
  );

  always_comb begin
    h_nxt       = '0;
    v_nxt       = '0;
    bar_cnt_nxt = '0;
    bar_idx_nxt = '0;
    pat_nxt     = pat_q;
    den_nxt     = 1'b0;
    hsync_nxt   = ~HS_POL;
    vsync_nxt   = ~VS_POL;
    pix_nxt     = '0;
    px_nxt      = '0;
    py_nxt      = '0;
    fs_nxt      = 1'b0;
    if (enable) begin
      h_nxt       = (h_cnt == H_LAST) ? '0 : h_cnt + HW'(1);
      v_nxt       = v_cnt;
      bar_cnt_nxt = bar_cnt;
      bar_idx_nxt = bar_idx;
      if (h_cnt == H_LAST) begin
        v_nxt       = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        bar_cnt_nxt = '0;
        bar_idx_nxt = '0;
      end else if (bar_idx != 3'd7) begin
        // The last bar never advances, so it absorbs the H_ACTIVE/8 remainder.
        if (bar_cnt == BAR_LAST) begin
          bar_cnt_nxt = '0;
          bar_idx_nxt = bar_idx + 3'd1;
        end else begin
          bar_cnt_nxt = bar_cnt + HW'(1);
        end
      end
      if (sof) pat_nxt = cur_pat;
      den_nxt   = h_act && v_act;
      hsync_nxt = (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : ~HS_POL;
      vsync_nxt = (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : ~VS_POL;
      pix_nxt   = (h_act && v_act) ? pix : '0;
      px_nxt    = (h_act && v_act) ? 12'(h_cnt) : '0;
      py_nxt    = v_act ? 11'(v_cnt) : '0;
      fs_nxt    = sof;
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      pat_q       <= PAT_BARS;
      den         <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      pixel_data  <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      bar_cnt     <= bar_cnt_nxt;
      bar_idx     <= bar_idx_nxt;
      pat_q       <= pat_nxt;
      den         <= den_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      pixel_data  <= pix_nxt;
      pixel_x     <= px_nxt;
      pixel_y     <= py_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_dvi_video_timing_gen.sv
// Directed self-checking bench: small raster (plus inverted-sync copy) for timing,
// enable and reset behaviour; a 64x40 raster for frame-latched pattern switching.
module tb_dvi_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, reset_m, enable_m;
  logic [1:0] pattern_sel, sel_m;

  logic den_s, hs_s, vs_s, fs_s, den_i, hs_i, vs_i, fs_i, den_m, hs_m, vs_m, fs_m;
  logic [23:0] pd_s, pd_i, pd_m;
  logic [11:0] px_s, px_i, px_m;
  logic [10:0] py_s, py_i, py_m;

  int total = 0;
  int bad   = 0;
  int m_k   = 0;

  localparam int MH = 72;
  localparam int MF = 72 * 44;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  dvi_video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .pixel_clock(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .den(den_s), .hsync(hs_s), .vsync(vs_s), .pixel_data(pd_s),
    .pixel_x(px_s), .pixel_y(py_s), .frame_start(fs_s)
  );

  dvi_video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_i (
    .pixel_clock(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .den(den_i), .hsync(hs_i), .vsync(vs_i), .pixel_data(pd_i),
    .pixel_x(px_i), .pixel_y(py_i), .frame_start(fs_i)
  );

  dvi_video_timing_gen #(
    .H_ACTIVE(64), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_m (
    .pixel_clock(clk), .reset(reset_m), .enable(enable_m), .pattern_sel(sel_m),
    .den(den_m), .hsync(hs_m), .vsync(vs_m), .pixel_data(pd_m),
    .pixel_x(px_m), .pixel_y(py_m), .frame_start(fs_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    m_k++;
  endtask

  // Advance the 64x40 raster until pixel (x,y) of frame f is on the outputs.
  task automatic goto_m(input int f, input int x, input int y);
    int target;
    target = f * MF + y * MH + x + 1;
    while (m_k < target) step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_den"}, 32'(den_s), 32'd0);
    check({tag, "_hsync"}, 32'(hs_s), 32'd0);
    check({tag, "_vsync"}, 32'(vs_s), 32'd0);
    check({tag, "_hsync_inv"}, 32'(hs_i), 32'd1);
    check({tag, "_vsync_inv"}, 32'(vs_i), 32'd1);
    check({tag, "_pixel"}, 32'(pd_s), 32'd0);
    check({tag, "_px"}, 32'(px_s), 32'd0);
    check({tag, "_py"}, 32'(py_s), 32'd0);
    check({tag, "_fs"}, 32'(fs_s), 32'd0);
  endtask

  initial begin
    int h, v, den_cnt, hs_cnt, vs_cnt, fs_cnt;
    bit e_den, e_hs, e_vs;
    reset = 1'b1; enable = 1'b1; pattern_sel = 2'd0;
    reset_m = 1'b1; enable_m = 1'b1; sel_m = 2'd0;
    den_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    step();
    step();
    check_idle("reset");

    reset = 1'b0;
    for (int k = 1; k <= 192; k++) begin
      step();
      h = (k - 1) % 24;
      v = (k - 1) / 24;
      e_den = (h < 16) && (v < 4);
      e_hs  = (h >= 18) && (h <= 20);
      e_vs  = (v >= 5) && (v <= 6);
      check("den", 32'(den_s), 32'(e_den));
      check("hsync", 32'(hs_s), 32'(e_hs));
      check("vsync", 32'(vs_s), 32'(e_vs));
      check("hsync_inv", 32'(hs_i), 32'(!e_hs));
      check("vsync_inv", 32'(vs_i), 32'(!e_vs));
      check("frame_start", 32'(fs_s), 32'((h == 0) && (v == 0)));
      check("pixel_x", 32'(px_s), e_den ? h : 0);
      check("pixel_y", 32'(py_s), (v < 4) ? v : 0);
      check("pixel_bars", 32'(pd_s), e_den ? 32'(bars[h / 2]) : 32'd0);
      den_cnt += int'(den_s);
      hs_cnt  += int'(hs_s);
      vs_cnt  += int'(vs_s);
      fs_cnt  += int'(fs_s);
    end
    check("den_per_frame", den_cnt, 64);
    check("hsync_per_frame", hs_cnt, 24);
    check("vsync_per_frame", vs_cnt, 48);
    check("fs_per_frame", fs_cnt, 1);
    step();
    check("fs_period", 32'(fs_s), 32'd1);

    // Drop enable while hsync is asserted, hold it low for 10 edges.
    repeat (19) step();
    check("pre_drop_hsync", 32'(hs_s), 32'd1);
    enable = 1'b0;
    step();
    check_idle("en_low");
    repeat (9) step();
    check("en_low_hold_den", 32'(den_s), 32'd0);
    check("en_low_hold_fs", 32'(fs_s), 32'd0);
    enable = 1'b1;
    step();
    check("reen_fs", 32'(fs_s), 32'd1);
    check("reen_den", 32'(den_s), 32'd1);
    check("reen_px", 32'(px_s), 32'd0);
    check("reen_py", 32'(py_s), 32'd0);
    check("reen_pixel", 32'(pd_s), 32'hFFFFFF);
    step();
    check("reen_px1", 32'(px_s), 32'd1);
    check("reen_pixel1", 32'(pd_s), 32'hFFFFFF);
    step();
    check("reen_px2", 32'(px_s), 32'd2);
    check("reen_pixel2", 32'(pd_s), 32'hFFFF00);

    // Asynchronous reset in the middle of active video.
    repeat (3) step();
    check("pre_rst_px", 32'(px_s), 32'd5);
    check("pre_rst_pixel", 32'(pd_s), 32'h00FFFF);
    #1 reset = 1'b1;
    #1 check_idle("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_rst_fs", 32'(fs_s), 32'd1);
    check("post_rst_den", 32'(den_s), 32'd1);
    check("post_rst_px", 32'(px_s), 32'd0);
    check("post_rst_pixel", 32'(pd_s), 32'hFFFFFF);

    // Pattern selection is latched only at the start of a frame.
    reset_m = 1'b0;
    m_k = 0;
    goto_m(0, 0, 0);
    check("m_fs0", 32'(fs_m), 32'd1);
    check("m_bar_00", 32'(pd_m), 32'hFFFFFF);
    goto_m(0, 40, 10);
    check("m_bar_40", 32'(pd_m), 32'hFF0000);
    sel_m = 2'd2;
    goto_m(0, 1, 11);
    check("m_keep_bar_1", 32'(pd_m), 32'hFFFFFF);
    goto_m(0, 40, 11);
    check("m_keep_bar_40", 32'(pd_m), 32'hFF0000);
    goto_m(0, 60, 12);
    check("m_keep_bar_60", 32'(pd_m), 32'h000000);
    goto_m(1, 0, 0);
    check("m_fs1", 32'(fs_m), 32'd1);
    check("m_chk_0_0", 32'(pd_m), 32'h000000);
    goto_m(1, 32, 0);
    check("m_chk_32_0", 32'(pd_m), 32'hFFFFFF);
    goto_m(1, 0, 32);
    check("m_chk_0_32", 32'(pd_m), 32'hFFFFFF);
    goto_m(1, 32, 32);
    check("m_chk_32_32", 32'(pd_m), 32'h000000);
    sel_m = 2'd1;
    goto_m(2, 37, 0);
    check("m_ramp_37", 32'(pd_m), 32'h252525);
    check("m_ramp_px", 32'(px_m), 32'd37);
    goto_m(2, 66, 1);
    check("m_blank_den", 32'(den_m), 32'd0);
    check("m_blank_pixel", 32'(pd_m), 32'd0);
    sel_m = 2'd3;
    goto_m(3, 5, 3);
    check("m_white", 32'(pd_m), 32'hFFFFFF);
    check("m_white_py", 32'(py_m), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
